// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and keeps one instruction-memory read outstanding at a time.
// Holds the returned word for decode and advances the PC from next_pc when that word retires.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    output logic [31:0] inst,
    input  logic        inst_ready,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        StReq,
        StWait,
        StHold,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StReq;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        unique case (state_q)
            // Responses arriving while a request is still pending acceptance are stale.
            StReq: begin
                if (imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = StFault;
                    end else begin
                        inst_d  = imem_rsp_data;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (inst_ready) begin
                    // Misaligned targets fault without disturbing the PC of the retired instruction.
                    if (next_pc[1:0] == 2'b00) begin
                        pc_d    = next_pc;
                        state_d = StReq;
                    end else begin
                        state_d = StFault;
                    end
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StFault;
            end
        endcase
    end

    // Reset masks the handshake outputs immediately rather than waiting for the edge.
    assign imem_req_valid = !rst && (state_q == StReq);
    assign inst_valid     = !rst && (state_q == StHold);
    assign imem_req_addr  = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign fetch_fault    = (state_q == StFault);

    addr_stable_a : assert property (@(posedge clk) disable iff (rst)
        (imem_req_valid && !imem_req_ready) |=> (imem_req_addr == $past(imem_req_addr)));

    fault_sticky_a : assert property (@(posedge clk) disable iff (rst)
        fetch_fault |=> fetch_fault);

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed test-plan scenarios followed by randomized traffic, all checked
// every cycle against a transaction-level model of the fetch loop.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic [31:0] inst;
    logic        inst_ready;
    logic        fetch_fault;

    always #5 clk = ~clk;

    ifu_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .next_pc        (next_pc),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_ready     (inst_ready),
        .fetch_fault    (fetch_fault)
    );

    int checks = 0;
    int failures = 0;

    // Model: where the current fetch stands, expressed as plain flags.
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_inst = '0;
    bit          m_pend = 0;
    bit          m_have = 0;
    bit          m_dead = 0;
    int          wait_cnt = 0;
    int          lat = 1;
    bit          armed = 0;
    int          cyc = 0;

    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    logic [31:0] s_pc, s_addr, s_inst;
    logic        s_rv, s_iv, s_ff;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs to the model, then advance the model.
    task automatic step(input bit r, input bit rdy, input bit ird, input logic [31:0] npc,
                        input bit err, input bit spur);
        bit          rv;
        bit          exp_rv;
        bit          exp_iv;
        logic [31:0] junk;
        @(negedge clk);
        rv = 0;
        if (m_pend) begin
            if (wait_cnt == 0) rv = 1;
            else wait_cnt--;
        end else if (spur && !m_have) begin
            rv = 1;
        end
        junk           = $urandom;
        rst            = r;
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_err   = rv ? err : junk[0];
        imem_rsp_data  = (rv && m_pend) ? word(m_pc) : $urandom;
        inst_ready     = ird;
        next_pc        = npc;
        #1;
        s_pc   = pc;
        s_addr = imem_req_addr;
        s_inst = inst;
        s_rv   = imem_req_valid;
        s_iv   = inst_valid;
        s_ff   = fetch_fault;
        if (armed) begin
            exp_rv = !r && !m_pend && !m_have && !m_dead;
            exp_iv = !r && m_have;
            chk("pc", s_pc, m_pc);
            chk("req_valid", 32'(s_rv), 32'(exp_rv));
            if (exp_rv) chk("req_addr", s_addr, m_pc);
            chk("inst_valid", 32'(s_iv), 32'(exp_iv));
            chk("inst", s_inst, m_inst);
            chk("fetch_fault", 32'(s_ff), 32'(m_dead));
        end
        if (r) begin
            m_pc   = RST_PC;
            m_inst = '0;
            m_pend = 0;
            m_have = 0;
            m_dead = 0;
        end else if (m_dead) begin
            m_dead = 1;
        end else if (m_pend) begin
            if (rv) begin
                m_pend = 0;
                if (err) m_dead = 1;
                else begin
                    m_have = 1;
                    m_inst = imem_rsp_data;
                end
            end
        end else if (m_have) begin
            if (ird) begin
                m_have = 0;
                if (npc[1:0] == 2'b00) m_pc = npc;
                else m_dead = 1;
            end
        end else if (rdy) begin
            m_pend   = 1;
            wait_cnt = lat - 1;
            acc_addr.push_back(m_pc);
            acc_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    initial begin
        int          n0;
        logic [31:0] tmp;
        logic [31:0] npc;

        // Reset held for two cycles.
        step(1, 1, 0, 32'h0, 0, 0);
        armed = 1;
        step(1, 1, 0, 32'h0, 0, 0);

        // Back-to-back zero-wait fetch.
        lat = 1;
        acc_addr.delete();
        acc_cyc.delete();
        step(0, 1, 1, m_pc + 32'd4, 0, 0);
        chk("rst_pc", s_pc, 32'h8000_0000);
        chk("rst_req_valid", 32'(s_rv), 32'd1);
        chk("rst_req_addr", s_addr, 32'h8000_0000);
        chk("rst_inst_valid", 32'(s_iv), 32'd0);
        chk("rst_fault", 32'(s_ff), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, m_pc + 32'd4, 0, 0);
        chk("b2b_count", 32'(acc_addr.size()), 32'd3);
        if (acc_addr.size() >= 3) begin
            chk("b2b_addr0", acc_addr[0], 32'h8000_0000);
            chk("b2b_addr1", acc_addr[1], 32'h8000_0004);
            chk("b2b_addr2", acc_addr[2], 32'h8000_0008);
            chk("b2b_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("b2b_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        // Request backpressure for four cycles, accepted on the fifth.
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 32'h0, 0, 0);
            chk("bp_req_valid", 32'(s_rv), 32'd1);
            chk("bp_req_addr", s_addr, 32'h8000_000C);
        end
        n0 = acc_addr.size();
        step(0, 1, 0, 32'h0, 0, 0);
        chk("bp_accept", 32'(acc_addr.size()), 32'(n0 + 1));

        // Consumer stall in HOLD, then redirect.
        step(0, 1, 0, 32'h0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 32'h0, 0, 0);
            chk("stall_inst_valid", 32'(s_iv), 32'd1);
            chk("stall_inst", s_inst, word(32'h8000_000C));
            chk("stall_pc", s_pc, 32'h8000_000C);
            chk("stall_no_req", 32'(s_rv), 32'd0);
        end
        step(0, 0, 1, 32'h8000_0100, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0);
        chk("redirect_addr", s_addr, 32'h8000_0100);
        chk("redirect_valid", 32'(s_rv), 32'd1);

        // Response error fault.
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 1, 0);
        n0 = acc_addr.size();
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 32'h0, 0, 1);
            chk("err_fault", 32'(s_ff), 32'd1);
            chk("err_no_req", 32'(s_rv), 32'd0);
        end
        chk("err_no_accept", 32'(acc_addr.size()), 32'(n0));

        // Misaligned next_pc fault.
        step(1, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 1, 1, 32'h8000_0102, 0, 0);
        step(0, 1, 0, 32'h0, 0, 0);
        chk("mis_fault", 32'(s_ff), 32'd1);
        chk("mis_pc", s_pc, 32'h8000_0000);

        // Reset while a response is pending; late response after release is dropped.
        step(1, 0, 0, 32'h0, 0, 0);
        lat = 3;
        step(0, 1, 0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 32'h0, 0, 1);
        chk("late_req_valid", 32'(s_rv), 32'd1);
        chk("late_req_addr", s_addr, 32'h8000_0000);
        chk("late_inst_valid", 32'(s_iv), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 32'h0, 0, 0);
            chk("late_still_req", 32'(s_rv), 32'd1);
            chk("late_no_inst", 32'(s_iv), 32'd0);
        end

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            int sel;
            lat = 1 + int'($urandom % 3);
            sel = int'($urandom % 100);
            tmp = $urandom;
            if (sel < 80) npc = m_pc + 32'd4;
            else if (sel < 90) npc = {tmp[31:2], 2'b00};
            else if (sel < 99) npc = m_pc;
            else npc = {tmp[31:2], 2'b00} | 32'(1 + $urandom % 3);
            step(($urandom % 150 == 0) || (m_dead && ($urandom % 8 == 0)),
                 ($urandom % 3) != 0, ($urandom % 3) != 0, npc,
                 ($urandom % 100) == 0, ($urandom % 4) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the single-issue RV32 core. Owns the architectural PC register, issues one instruction-memory read at a time over a valid/ready request channel, and captures the returned word. It presents the word to decode/execute and loads the PC from the combinational next-PC logic when the instruction is consumed. It sits directly upstream of decode and consumes the next-PC selector's `next_pc` output.

## Interface
Parameters:
- `RESET_PC`, 32'h8000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `next_pc`  in  32  target PC from next-PC logic, valid while `inst_valid`=1.
- `pc`  out  32  current PC (address of the instruction being fetched or held).
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  32  read address; equals `pc`.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_rsp_valid`  in  1  read data valid.
- `imem_rsp_data`  in  32  returned instruction word.
- `imem_rsp_err`  in  1  access fault, qualified by `imem_rsp_valid`.
- `inst_valid`  out  1  `inst` holds the word for `pc`.
- `inst`  out  32  registered instruction word.
- `inst_ready`  in  1  consumer retires the held instruction this cycle.
- `fetch_fault`  out  1  sticky fault flag.

## Operation
- States: REQ, WAIT, HOLD, FAULT.
- REQ: `imem_req_valid`=1, `imem_req_addr`=`pc`. On `imem_req_ready`=1 -> WAIT. `imem_rsp_valid` is ignored in REQ.
- WAIT: request outstanding, `imem_req_valid`=0. On `imem_rsp_valid`=1 with `imem_rsp_err`=0: `inst` <= `imem_rsp_data`, -> HOLD. On `imem_rsp_valid`=1 with `imem_rsp_err`=1 -> FAULT, `inst` unchanged.
- HOLD: `inst_valid`=1, `inst` stable. On `inst_ready`=1: if `next_pc[1:0]`==0, `pc` <= `next_pc`, -> REQ; else -> FAULT, `pc` unchanged. `inst_ready`=0 leaves everything unchanged.
- FAULT: all request/valid outputs 0, `fetch_fault`=1; exits only via `rst`.
- Exactly one outstanding request. `pc` changes only on the HOLD->REQ transition or on reset.
- `next_pc` with `next_pc`==`pc` (self-loop) is legal and refetches the same address.
- `inst_valid`=0 outside HOLD; `inst` keeps its last captured value.
- `inst_ready` outside HOLD is ignored.

## Timing
- With `rst`=1 at a rising edge, the following state is: `pc`=`RESET_PC`, state REQ, `inst`=0, `fetch_fault`=0. While `rst` is high, `imem_req_valid`=0 and `inst_valid`=0, forced combinationally.
- The first request is visible in the first cycle with `rst`=0.
- Reset mid-WAIT or mid-HOLD abandons the instruction. A late `imem_rsp_valid` arriving in REQ after reset is dropped.
- The memory must not return `imem_rsp_valid` in the same cycle its request is accepted. The earliest response is the cycle after acceptance.
- Minimum per-instruction cycle count is 3: request accepted in cycle N, response in N+1, `inst_valid` in N+2 with `inst_ready`=1, and the new request in N+3.
- `imem_req_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0.
- `fetch_fault` rises in the cycle after the faulting edge and stays high until reset.

## Test plan
- Reset: hold `rst` 2 cycles, then release -> `pc`=0x8000_0000, `imem_req_valid`=1, `imem_req_addr`=0x8000_0000, `inst_valid`=0, `fetch_fault`=0.
- Back-to-back fetch with zero-wait memory, `inst_ready`=1, and `next_pc`=`pc`+4 -> addresses 0x8000_0000, 0x8000_0004, 0x8000_0008 issued every 3 cycles. `inst` matches the memory words.
- Request backpressure: `imem_req_ready`=0 for 4 cycles -> `imem_req_valid` and `imem_req_addr` stay constant. The request is accepted on the 5th cycle.
- Consumer stall: `inst_ready`=0 for 3 cycles in HOLD -> `inst`, `pc`, and `inst_valid`=1 are unchanged, with no new request. Raising `inst_ready` with `next_pc`=0x8000_0100 -> the next request address is 0x8000_0100.
- Faults: `imem_rsp_err`=1 -> `fetch_fault`=1 and no further requests. In a separate run, `next_pc`=0x8000_0102 while retiring -> `fetch_fault`=1 and `pc` stays at the old value.
- Reset in WAIT: assert `rst` while a response is pending, then deliver `imem_rsp_valid` 1 cycle after release -> the response is ignored, a fresh request is issued to 0x8000_0000, and `inst_valid` stays 0.
